serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract controller that sequences a single-bit adder cell

---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - host handshake and operand/result bundle for serial_add_ctrl
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around a two-half-adder cell
module half_adder (
    input  logic x,
    input  logic y,
    output logic C,
    output logic S
);
    assign S = x ^ y;
    assign C = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             p, g, s, t, c_next;
    logic [WIDTH-1:0] full;

    // Full-adder cell: propagate/generate from the operand bits, then fold in the carry.
    half_adder u_ha0 (.x(a_sh_q[0]), .y(b_sh_q[0]), .C(g), .S(p));
    half_adder u_ha1 (.x(p),         .y(carry_q),   .C(t), .S(s));

    assign c_next = g | t;
    assign full   = {s, res_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                res_d   = full[WIDTH-1:1];
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB stage.
                    sum_d   = full;
                    cout_d  = c_next;
                    ovf_d   = c_next ^ carry_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized and directed checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    bit   chk_en;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of an operation from plain integer arithmetic: {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ai, bi, r, sa, sb, sr;
        logic c, o;
        ai = int'(a);
        bi = int'(b);
        sa = (ai >= 128) ? ai - 256 : ai;
        sb = (bi >= 128) ? bi - 256 : bi;
        if (s) begin
            r  = ai - bi;
            c  = (ai >= bi);
            sr = sa - sb;
        end else begin
            r  = ai + bi;
            c  = (r > 255);
            sr = sa + sb;
        end
        o = (sr > 127) || (sr < -128);
        return {o, c, W'(r & 255)};
    endfunction

    // Model: edges remaining until the controller is idle again after an accepted start.
    int           m_cd;
    logic [W-1:0] m_sum, p_a, p_b;
    logic         m_cout, m_ovf, p_sub;
    logic [W+1:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cd   = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_cd == 0) begin
            if (bus.start) begin
                p_a   = bus.a;
                p_b   = bus.b;
                p_sub = bus.sub;
                m_cd  = W + 1;
            end
        end else begin
            m_cd = m_cd - 1;
            if (m_cd == 1) begin
                m_res  = ref_op(p_a, p_b, p_sub);
                m_sum  = m_res[W-1:0];
                m_cout = m_res[W];
                m_ovf  = m_res[W+1];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", 32'(bus.ready), 32'(m_cd == 0));
            chk("cyc_busy",  32'(bus.busy),  32'(m_cd >= 2));
            chk("cyc_done",  32'(bus.done),  32'(m_cd == 1));
            chk("cyc_sum",   32'(bus.sum),   32'(m_sum));
            chk("cyc_cout",  32'(bus.cout),  32'(m_cout));
            chk("cyc_ovf",   32'(bus.ovf),   32'(m_ovf));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = int'(bus.busy);
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            lat++;
            busy_cnt += int'(bus.busy);
            if (bus.done) seen = 1'b1;
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat, bc;
        issue(a, b, s);
        wait_done(lat, bc);
        chk({name, "_sum"},  32'(bus.sum),  32'(es));
        chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({name, "_ovf"},  32'(bus.ovf),  32'(eo));
        cyc();
    endtask

    initial begin
        int lat, bc, dcnt;
        n_chk     = 0;
        n_err     = 0;
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_sum",   32'(bus.sum),   32'd0);
        chk("rst_cout",  32'(bus.cout),  32'd0);
        chk("rst_ovf",   32'(bus.ovf),   32'd0);
        chk_en = 1'b1;

        issue(8'h00, 8'h00, 1'b0);
        wait_done(lat, bc);
        chk("zero_latency", 32'(lat), 32'(W));
        chk("zero_sum", 32'(bus.sum), 32'h00);
        chk("zero_cout", 32'(bus.cout), 32'd0);
        cyc();

        issue(8'hFF, 8'h01, 1'b0);
        wait_done(lat, bc);
        chk("ff01_busy_cycles", 32'(bc), 32'(W));
        chk("ff01_sum", 32'(bus.sum), 32'h00);
        chk("ff01_cout", 32'(bus.cout), 32'd1);
        chk("ff01_ovf", 32'(bus.ovf), 32'd0);
        cyc();

        run_op("sub0507", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Stray starts while running and while done is high must be ignored.
        issue(8'h12, 8'h34, 1'b0);
        repeat (3) cyc();
        bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_done(lat, bc);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("ign_sum", 32'(bus.sum), 32'h46);
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            dcnt += int'(bus.done);
        end
        chk("ign_extra_done", 32'(dcnt), 32'd0);
        chk("ign_sum_held", 32'(bus.sum), 32'h46);

        // Reset in the fourth RUN cycle aborts the operation at once.
        issue(8'h3C, 8'h21, 1'b0);
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        chk("mid_rst_busy",  32'(bus.busy),  32'd0);
        chk("mid_rst_sum",   32'(bus.sum),   32'h00);
        #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            dcnt += int'(bus.done);
        end
        chk("mid_rst_no_done", 32'(dcnt), 32'd0);
        run_op("add0a05", 8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.sub   = 1'($urandom);
            bus.start = ($urandom_range(0, 2) == 0);
            cyc();
        end
        bus.start = 1'b0;
        repeat (12) cyc();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
